// File: rtl/chain_route_ctrl_if.sv
// Bus bundle for the daisy-chain route table builder.
// Groups the build handshake, the resulting chain summary and the
// table read port so the controller and its user share one port.
interface chain_route_ctrl_if #(
    parameter int NUM_DEV = 18,
    parameter int IDX_W   = 5
);
    logic               start;
    logic [NUM_DEV:0]   active_chains;
    logic               busy;
    logic               done;
    logic [IDX_W-1:0]   chain_len;
    logic [IDX_W-1:0]   first_node;
    logic [IDX_W-1:0]   last_node;
    logic [IDX_W-1:0]   rd_addr;
    logic [IDX_W-1:0]   rd_tdi;
    logic [IDX_W-1:0]   rd_tdo;

    modport master (
        output start,
        output active_chains,
        output rd_addr,
        input  busy,
        input  done,
        input  chain_len,
        input  first_node,
        input  last_node,
        input  rd_tdi,
        input  rd_tdo
    );

    modport slave (
        input  start,
        input  active_chains,
        input  rd_addr,
        output busy,
        output done,
        output chain_len,
        output first_node,
        output last_node,
        output rd_tdi,
        output rd_tdo
    );
endinterface

// File: rtl/chain_route_ctrl.sv
// Daisy-chain route table builder.
// On start, the set of present devices is captured and walked once in
// ascending index order. Each present device gets a TDI source (the
// previous present device, or the FIRST marker) and the previous device
// gets this one as its TDO destination; the last present device drains
// to the LAST marker. Absent devices keep the NULL marker. The finished
// table is readable through a registered one-cycle read port.
module chain_route_ctrl #(
    parameter int NUM_DEV = 18,
    parameter int IDX_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    chain_route_ctrl_if.slave bus
);
    // Marker values sit just above the real device indices.
    localparam logic [IDX_W-1:0] FIRST_INDEX = IDX_W'(NUM_DEV + 1);
    localparam logic [IDX_W-1:0] LAST_INDEX  = IDX_W'(NUM_DEV + 2);
    localparam logic [IDX_W-1:0] NULL_INDEX  = IDX_W'(NUM_DEV + 3);
    localparam logic [IDX_W-1:0] SCAN_END    = IDX_W'(NUM_DEV);

    // Address width needed to select one of the NUM_DEV+1 table entries.
    localparam int AW = (NUM_DEV > 0) ? $clog2(NUM_DEV + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COMMIT,
        DONE
    } state_t;

    state_t           state;
    logic [NUM_DEV:0] snap;
    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] prev;
    logic [IDX_W-1:0] chain_len;
    logic [IDX_W-1:0] first_node;
    logic [IDX_W-1:0] last_node;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] rd_tdi;
    logic [IDX_W-1:0] rd_tdo;
    logic [IDX_W-1:0] tdi_tab [NUM_DEV+1];
    logic [IDX_W-1:0] tdo_tab [NUM_DEV+1];

    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.chain_len  = chain_len;
    assign bus.first_node = first_node;
    assign bus.last_node  = last_node;
    assign bus.rd_tdi     = rd_tdi;
    assign bus.rd_tdo     = rd_tdo;

    // Build FSM: snapshot, walk one index per cycle, close the chain, hold result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            snap       <= '0;
            scan_idx   <= '0;
            prev       <= FIRST_INDEX;
            chain_len  <= '0;
            first_node <= NULL_INDEX;
            last_node  <= NULL_INDEX;
            for (int i = 0; i <= NUM_DEV; i++) begin
                tdi_tab[i] <= NULL_INDEX;
                tdo_tab[i] <= NULL_INDEX;
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        snap      <= bus.active_chains;
                        scan_idx  <= '0;
                        prev      <= FIRST_INDEX;
                        chain_len <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        state     <= SCAN;
                        for (int i = 0; i <= NUM_DEV; i++) begin
                            tdi_tab[i] <= NULL_INDEX;
                            tdo_tab[i] <= NULL_INDEX;
                        end
                    end
                end
                SCAN: begin
                    if (snap[scan_idx[AW-1:0]]) begin
                        tdi_tab[scan_idx[AW-1:0]] <= prev;
                        if (prev == FIRST_INDEX) begin
                            first_node <= scan_idx;
                        end else begin
                            tdo_tab[prev[AW-1:0]] <= scan_idx;
                        end
                        prev      <= scan_idx;
                        chain_len <= chain_len + 1'b1;
                    end
                    if (scan_idx == SCAN_END) begin
                        state <= COMMIT;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                COMMIT: begin
                    if (prev != FIRST_INDEX) begin
                        tdo_tab[prev[AW-1:0]] <= LAST_INDEX;
                        last_node             <= prev;
                    end else begin
                        first_node <= NULL_INDEX;
                        last_node  <= NULL_INDEX;
                        chain_len  <= '0;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Registered table read; only a finished table with an in-range address is visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_tdi <= NULL_INDEX;
            rd_tdo <= NULL_INDEX;
        end else if (state == DONE && bus.rd_addr <= SCAN_END) begin
            rd_tdi <= tdi_tab[bus.rd_addr[AW-1:0]];
            rd_tdo <= tdo_tab[bus.rd_addr[AW-1:0]];
        end else begin
            rd_tdi <= NULL_INDEX;
            rd_tdo <= NULL_INDEX;
        end
    end
endmodule

// File: tb/tb_chain_route_ctrl.sv
// Testbench for chain_route_ctrl.
// A driver issues directed builds, reads and status probes and queues the
// hand-computed expected responses; a monitor on the falling edge pops
// and compares them, and separately times start-to-done latency.
`timescale 1ns/1ps
module tb_chain_route_ctrl;
    localparam int NUM_DEV = 18;
    localparam int IDX_W   = 5;

    typedef struct {
        int         kind;
        string      name;
        logic       busy;
        logic       done;
        logic [4:0] len;
        logic [4:0] first;
        logic [4:0] last;
        logic [4:0] tdi;
        logic [4:0] tdo;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    exp_t expQ[$];
    int   latQ[$];
    int   checks = 0;
    int   errors = 0;
    logic reqValid = 1'b0;
    logic latArm = 1'b0;
    logic pend = 1'b0;
    int   latCnt = 0;
    logic latRun = 1'b0;

    chain_route_ctrl_if #(.NUM_DEV(NUM_DEV), .IDX_W(IDX_W)) bus ();

    chain_route_ctrl #(.NUM_DEV(NUM_DEV), .IDX_W(IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock well under 40 MHz.
    always #15 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushRead(input int addr, input int tdi, input int tdo, input string name);
        exp_t e;
        e.kind  = 0;
        e.name  = name;
        e.busy  = 1'b0;
        e.done  = 1'b0;
        e.len   = '0;
        e.first = '0;
        e.last  = '0;
        e.tdi   = 5'(tdi);
        e.tdo   = 5'(tdo);
        expQ.push_back(e);
        bus.rd_addr = 5'(addr);
        reqValid    = 1'b1;
        tick();
        reqValid    = 1'b0;
    endtask

    task automatic pushStatus(input string name, input logic b, input logic d,
                              input int len, input int first, input int last);
        exp_t e;
        e.kind  = 1;
        e.name  = name;
        e.busy  = b;
        e.done  = d;
        e.len   = 5'(len);
        e.first = 5'(first);
        e.last  = 5'(last);
        e.tdi   = '0;
        e.tdo   = '0;
        expQ.push_back(e);
        reqValid = 1'b1;
        tick();
        reqValid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [NUM_DEV:0] chains, input bit expectLat,
                                 input bit checkHs);
        exp_t e;
        bus.active_chains = chains;
        bus.start         = 1'b1;
        latArm            = expectLat;
        if (expectLat) latQ.push_back(NUM_DEV + 2);
        if (checkHs) begin
            e.kind  = 2;
            e.name  = "start_handshake";
            e.busy  = 1'b1;
            e.done  = 1'b0;
            e.len   = '0;
            e.first = '0;
            e.last  = '0;
            e.tdi   = '0;
            e.tdo   = '0;
            expQ.push_back(e);
            reqValid = 1'b1;
        end
        tick();
        bus.start = 1'b0;
        latArm    = 1'b0;
        reqValid  = 1'b0;
    endtask

    task automatic waitDone(input string name);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (bus.done !== 1'b1) checkOutput({name, ".done_timeout"}, 32'(bus.done), 32'd1);
    endtask

    // Monitor: compare each queued response one edge after its request, and time done.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (pend) begin
                if (expQ.size() == 0) begin
                    checkOutput("scoreboard_underflow", 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    if (e.kind == 0) begin
                        checkOutput({e.name, ".tdi"}, 32'(bus.rd_tdi), 32'(e.tdi));
                        checkOutput({e.name, ".tdo"}, 32'(bus.rd_tdo), 32'(e.tdo));
                    end else begin
                        checkOutput({e.name, ".busy"}, 32'(bus.busy), 32'(e.busy));
                        checkOutput({e.name, ".done"}, 32'(bus.done), 32'(e.done));
                        if (e.kind == 1) begin
                            checkOutput({e.name, ".chain_len"}, 32'(bus.chain_len), 32'(e.len));
                            checkOutput({e.name, ".first_node"}, 32'(bus.first_node), 32'(e.first));
                            checkOutput({e.name, ".last_node"}, 32'(bus.last_node), 32'(e.last));
                        end
                    end
                end
            end
            pend = reqValid;
            if (bus.start === 1'b1 && latArm) begin
                latCnt = -1;
                latRun = 1'b1;
            end else if (latRun) begin
                latCnt++;
                if (bus.done === 1'b1) begin
                    latRun = 1'b0;
                    if (latQ.size() == 0) checkOutput("latency_underflow", 32'd1, 32'd0);
                    else checkOutput("done_latency", 32'(latCnt), 32'(latQ.pop_front()));
                end else if (latCnt > 200) begin
                    latRun = 1'b0;
                    checkOutput("latency_timeout", 32'(latCnt), 32'(NUM_DEV + 2));
                end
            end
        end
    end

    // Watchdog so a stuck run still ends with a visible failure.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Driver: directed scenarios with hand-computed tables.
    initial begin
        bus.start         = 1'b0;
        bus.active_chains = '0;
        bus.rd_addr       = '0;
        tick();
        tick();
        pushStatus("reset", 1'b0, 1'b0, 0, 21, 21);
        pushRead(0, 21, 21, "reset_rd");
        rst = 1'b0;
        tick();

        $display("[TB] sparse chain 0x00025");
        applyStimulus(19'h00025, 1'b1, 1'b0);
        waitDone("sparse");
        pushStatus("sparse", 1'b0, 1'b1, 3, 0, 5);
        pushRead(0, 19, 2, "sparse_rd0");
        pushRead(2, 0, 5, "sparse_rd2");
        pushRead(5, 2, 20, "sparse_rd5");
        pushRead(1, 21, 21, "sparse_rd1");
        pushRead(25, 21, 21, "sparse_rd_oob");

        $display("[TB] empty chain");
        applyStimulus(19'h00000, 1'b1, 1'b0);
        waitDone("empty");
        pushStatus("empty", 1'b0, 1'b1, 0, 21, 21);
        pushRead(0, 21, 21, "empty_rd0");
        pushRead(18, 21, 21, "empty_rd18");

        $display("[TB] full chain");
        applyStimulus(19'h7FFFF, 1'b1, 1'b0);
        waitDone("full");
        pushStatus("full", 1'b0, 1'b1, 19, 0, 18);
        for (int i = 0; i <= NUM_DEV; i++) begin
            pushRead(i, (i == 0) ? 19 : i - 1, (i == NUM_DEV) ? 20 : i + 1,
                     $sformatf("full_rd%0d", i));
        end

        $display("[TB] snapshot and ignored start");
        applyStimulus(19'h00412, 1'b1, 1'b0);
        repeat (3) tick();
        bus.active_chains = 19'h7FFFF;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.active_chains = 19'h00000;
        waitDone("snap");
        pushStatus("snap", 1'b0, 1'b1, 3, 1, 10);
        pushRead(1, 19, 4, "snap_rd1");
        pushRead(4, 1, 10, "snap_rd4");
        pushRead(10, 4, 20, "snap_rd10");
        pushRead(0, 21, 21, "snap_rd0");
        pushRead(18, 21, 21, "snap_rd18");

        $display("[TB] reset mid-scan");
        applyStimulus(19'h7FFFF, 1'b0, 1'b0);
        repeat (7) tick();
        rst = 1'b1;
        pushStatus("midreset", 1'b0, 1'b0, 0, 21, 21);
        rst = 1'b0;
        pushRead(3, 21, 21, "midreset_rd3");
        applyStimulus(19'h7FFFF, 1'b1, 1'b0);
        waitDone("after_reset");
        pushStatus("after_reset", 1'b0, 1'b1, 19, 0, 18);
        pushRead(5, 4, 6, "after_reset_rd5");

        $display("[TB] rebuild from done");
        applyStimulus(19'h40001, 1'b1, 1'b1);
        waitDone("rebuild");
        pushStatus("rebuild", 1'b0, 1'b1, 2, 0, 18);
        pushRead(0, 19, 18, "rebuild_rd0");
        pushRead(18, 0, 20, "rebuild_rd18");
        pushRead(9, 21, 21, "rebuild_rd9");

        repeat (3) tick();
        checkOutput("scoreboard_drained", 32'(expQ.size() + latQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/chain_route_ctrl.md
CHAIN_ROUTE_CTRL -- requirements
Module: chain_route_ctrl

Interface
REQ-001 Parameter NUM_DEV, default 18: highest device index; devices are numbered 0..NUM_DEV.
REQ-002 Parameter IDX_W, default 5: index width; SHALL satisfy 2^IDX_W > NUM_DEV+3.
REQ-003 Derived constants: FIRST_INDEX = NUM_DEV+1, LAST_INDEX = NUM_DEV+2, NULL_INDEX = NUM_DEV+3.
REQ-004 clk  input  1  logic clock, 40 MHz or less; single clock domain.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to build the route table.
REQ-007 active_chains  input  NUM_DEV+1  daisy-chain vector; bit i high means device i is present.
REQ-008 busy  output  1  build in progress.
REQ-009 done  output  1  route table valid.
REQ-010 chain_len  output  IDX_W  number of active devices.
REQ-011 first_node  output  IDX_W  lowest active index, or NULL_INDEX.
REQ-012 last_node  output  IDX_W  highest active index, or NULL_INDEX.
REQ-013 rd_addr  input  IDX_W  table read address.
REQ-014 rd_tdi  output  IDX_W  TDI source of node rd_addr.
REQ-015 rd_tdo  output  IDX_W  TDO destination of node rd_addr.

Function
REQ-016 FSM states: IDLE, SCAN, COMMIT, DONE.
REQ-017 IDLE or DONE with start=1: snapshot active_chains, set every table entry to NULL_INDEX, set scan index to 0, set prev to FIRST_INDEX, set chain_len to 0, drop done, go to SCAN.
REQ-018 start in SCAN or COMMIT SHALL be ignored; there is no queued restart.
REQ-019 Changes to active_chains after the snapshot SHALL NOT affect the build in progress.
REQ-020 SCAN processes one index per cycle, in ascending order from 0 to NUM_DEV.
REQ-021 SCAN, inactive index: tdi and tdo entries of that index stay NULL_INDEX.
REQ-022 SCAN, active index i:
- tdi[i] = prev.
- If prev == FIRST_INDEX, first_node = i; otherwise tdo[prev] = i.
- Then prev = i and chain_len increments.
REQ-023 After index NUM_DEV is processed, go to COMMIT.
REQ-024 COMMIT, non-empty chain: tdo[prev] = LAST_INDEX and last_node = prev.
REQ-025 COMMIT, empty chain: first_node = last_node = NULL_INDEX and chain_len = 0.
REQ-026 COMMIT always goes to DONE.
REQ-027 busy SHALL be 1 exactly in SCAN and COMMIT.
REQ-028 done SHALL be 1 exactly in DONE.
REQ-029 Latency: done rises NUM_DEV+2 clock edges after the edge that samples start.
REQ-030 Read port: registered, one-cycle latency.
- rd_addr > NUM_DEV returns NULL_INDEX on both rd_tdi and rd_tdo.
- When not in DONE, reads return NULL_INDEX on both outputs.
REQ-031 chain_len arithmetic is unsigned IDX_W bits; the maximum is NUM_DEV+1, so there is no overflow.
REQ-032 Table storage: NUM_DEV+1 entries each for tdi and tdo; indices are never wrapped.

Reset
REQ-033 rst=1 at a clock edge, in any state including mid-SCAN:
- State goes to IDLE.
- busy=0, done=0, chain_len=0.
- first_node, last_node and all table entries go to NULL_INDEX.
- rd_tdi = rd_tdo = NULL_INDEX on the next edge.
REQ-034 rst has priority over start in the same cycle.

Verification
REQ-035 Sparse chain: active_chains=0x00025 (bits 0,2,5), start pulse. Required response:
- done after 20 edges, chain_len=3, first_node=0, last_node=5.
- tdi[0]=19, tdo[0]=2, tdi[2]=0, tdo[2]=5, tdi[5]=2, tdo[5]=20.
- tdi[1] = tdo[1] = 21.
REQ-036 Empty chain: active_chains=0, start pulse. Required response: done, chain_len=0, first_node=last_node=21, every read returns 21.
REQ-037 Full chain: all 19 bits set. Required response:
- tdi[0]=19, tdo[18]=20.
- tdi[i]=i-1 for i in 1..18.
- chain_len=19.
REQ-038 Snapshot and start during busy: active_chains changes and start pulses during SCAN. Required response: the table matches the original snapshot, and done arrives at the original 20-edge deadline.
REQ-039 Reset mid-scan: rst at scan index 7. Required response: next cycle busy=0, done=0, rd_tdi=21. A new start then completes normally.
REQ-040 Rebuild from DONE: start in DONE with new active_chains=0x40001. Required response:
- done drops on the next edge, then reasserts 20 edges after start.
- tdo[0]=18, tdi[18]=0.
